// File: rtl/grid_decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : grid_decode_pkg
//  Description : Shared types and helpers for the grid decode sequencer:
//                round state encoding, node count and index-to-(y,x) mapping.
//  Revision    : 1.0 - initial release
// ============================================================================
package grid_decode_pkg;

    // Round phases; explicit 3-bit encoding
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        OFFER  = 3'd3,
        STOP   = 3'd4,
        SCAN   = 3'd5,
        FINISH = 3'd6
    } seq_state_t;

    // Phase counters are 16 bits; legal delay ranges never reach a wrap
    localparam int c_counter_width = 16;

    // Consecutive converged cycles needed to cut an offer phase short
    localparam int c_converge_run = 4;

    // Total node count of a height x width grid
    function automatic int num_nodes(input int height, input int width);
        return height * width;
    endfunction

    // Row-major node index to row (y)
    function automatic int node_row(input int idx, input int width);
        return idx / width;
    endfunction

    // Row-major node index to column (x)
    function automatic int node_col(input int idx, input int width);
        return idx % width;
    endfunction

endpackage : grid_decode_pkg
`default_nettype wire

// File: rtl/grid_decode_sequencer_defect_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : defect_scanner
//  Description : Walks the captured syndrome in row-major order, skipping
//                clear nodes one per cycle and presenting one result beat per
//                defect node with a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module defect_scanner
    import grid_decode_pkg::*;
#(
    parameter int NUM_NODES         = 6,
    parameter int GRID_WIDTH        = 3,
    parameter int CORDINATE_WIDTH   = 4,
    parameter int MATCH_VALUE_WIDTH = 2 * CORDINATE_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic                                   scan_en,
    input  logic [NUM_NODES-1:0]                   syndrome,
    input  logic [NUM_NODES*MATCH_VALUE_WIDTH-1:0] match_value_in,
    input  logic                                   res_ready,
    output logic                                   res_valid,
    output logic [CORDINATE_WIDTH-1:0]             res_y,
    output logic [CORDINATE_WIDTH-1:0]             res_x,
    output logic [MATCH_VALUE_WIDTH-1:0]           res_match,
    output logic                                   scan_done
);

    localparam int c_idx_width = $clog2(NUM_NODES + 1);
    localparam logic [c_idx_width-1:0] c_last_idx = c_idx_width'(NUM_NODES - 1);

    logic [c_idx_width-1:0] r_idx;
    logic                   w_defect;
    logic                   w_advance;
    logic                   w_last;

    // Defect detection, advance condition and gated result payload
    always_comb begin
        w_defect  = scan_en & syndrome[r_idx];
        w_advance = scan_en & (~syndrome[r_idx] | res_ready);
        w_last    = (r_idx == c_last_idx);
        scan_done = w_advance & w_last;
        res_valid = w_defect;
        res_y     = '0;
        res_x     = '0;
        res_match = '0;
        if (w_defect) begin
            res_y     = CORDINATE_WIDTH'(node_row(int'(r_idx), GRID_WIDTH));
            res_x     = CORDINATE_WIDTH'(node_col(int'(r_idx), GRID_WIDTH));
            res_match = match_value_in[int'(r_idx)*MATCH_VALUE_WIDTH +: MATCH_VALUE_WIDTH];
        end
    end

    // Node index: cleared on start, held while a defect beat is stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx <= '0;
        end else if (start) begin
            r_idx <= '0;
        end else if (w_advance && !w_last) begin
            r_idx <= r_idx + c_idx_width'(1);
        end
    end

endmodule : defect_scanner
`default_nettype wire

// File: rtl/grid_decode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : grid_decode_sequencer
//  Description : Drives one stabilizer grid through a decode round: load the
//                syndrome, settle, offer for a cycle budget, stop, then stream
//                (y, x, match) for every defect node.
//                Optional early stop on grid convergence: define
//                GRID_DECODE_SEQ_EARLY_STOP_EN (adds converged / timed_out).
//  Revision    : 1.0 - initial release
// ============================================================================
module grid_decode_sequencer
    import grid_decode_pkg::*;
#(
    parameter int GRID_HEIGHT       = 2,
    parameter int GRID_WIDTH        = 3,
    parameter int CORDINATE_WIDTH   = 4,
    parameter int MATCH_VALUE_WIDTH = 2 * CORDINATE_WIDTH,
    parameter int SETTLE_CYCLES     = 100,
    parameter int OFFER_CYCLES      = 2500,
    localparam int NUM_NODES        = num_nodes(GRID_HEIGHT, GRID_WIDTH)
) (
    input  logic                                   clk,
    input  logic                                   reset,
`ifdef GRID_DECODE_SEQ_EARLY_STOP_EN
    input  logic                                   converged,
    output logic                                   timed_out,
`endif
    input  logic                                   syn_valid,
    output logic                                   syn_ready,
    input  logic [NUM_NODES-1:0]                   syn_data,
    output logic [NUM_NODES-1:0]                   measurement_value_out,
    output logic                                   measurement_valid_out,
    output logic                                   start_offer,
    output logic                                   stop_offer,
    input  logic [NUM_NODES*MATCH_VALUE_WIDTH-1:0] match_value_in,
    output logic                                   res_valid,
    input  logic                                   res_ready,
    output logic [CORDINATE_WIDTH-1:0]             res_y,
    output logic [CORDINATE_WIDTH-1:0]             res_x,
    output logic [MATCH_VALUE_WIDTH-1:0]           res_match,
    output logic                                   done,
    output logic                                   busy
);

    localparam logic [c_counter_width-1:0] c_settle_last = c_counter_width'(SETTLE_CYCLES - 1);
    localparam logic [c_counter_width-1:0] c_offer_last  = c_counter_width'(OFFER_CYCLES - 1);

    seq_state_t                 r_state,    w_state_next;
    logic [c_counter_width-1:0] r_cnt,      w_cnt_next;
    logic [NUM_NODES-1:0]       r_syndrome, w_syndrome_next;
    logic                       w_scan_start;
    logic                       w_scan_en;
    logic                       w_scan_done;
`ifdef GRID_DECODE_SEQ_EARLY_STOP_EN
    logic [2:0]                 r_conv_run, w_conv_run_next;
    logic                       r_timed_out, w_timed_out_next;
    logic                       w_early;
`endif

    assign w_scan_start          = (r_state == STOP);
    assign w_scan_en             = (r_state == SCAN);
    assign busy                  = (r_state != IDLE);
    assign measurement_value_out = r_syndrome;
`ifdef GRID_DECODE_SEQ_EARLY_STOP_EN
    assign timed_out             = r_timed_out;
`endif

    // Next-state, counter and strobe decode
    always_comb begin
        w_state_next          = r_state;
        w_cnt_next            = r_cnt;
        w_syndrome_next       = r_syndrome;
        syn_ready             = 1'b0;
        measurement_valid_out = 1'b0;
        start_offer           = 1'b0;
        stop_offer            = 1'b0;
        done                  = 1'b0;
`ifdef GRID_DECODE_SEQ_EARLY_STOP_EN
        w_conv_run_next       = '0;
        w_timed_out_next      = r_timed_out;
        w_early               = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                syn_ready = 1'b1;
                if (syn_valid) begin
                    w_syndrome_next = syn_data;
`ifdef GRID_DECODE_SEQ_EARLY_STOP_EN
                    w_timed_out_next = 1'b0;
`endif
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                measurement_valid_out = 1'b1;
                w_cnt_next            = '0;
                // Nothing to decode: skip straight to the end of round
                w_state_next = (r_syndrome == '0) ? FINISH : SETTLE;
            end
            SETTLE: begin
                if (r_cnt == c_settle_last) begin
                    w_cnt_next   = '0;
                    w_state_next = OFFER;
                end else begin
                    w_cnt_next = r_cnt + c_counter_width'(1);
                end
            end
            OFFER: begin
                start_offer = (r_cnt == '0);
                w_cnt_next  = r_cnt + c_counter_width'(1);
`ifdef GRID_DECODE_SEQ_EARLY_STOP_EN
                // The start_offer cycle never counts towards convergence
                if (r_cnt != '0 && converged) begin
                    w_conv_run_next = r_conv_run + 3'd1;
                    w_early = (r_conv_run == 3'(c_converge_run - 1));
                end
                if (w_early) begin
                    w_state_next = STOP;
                end else if (r_cnt == c_offer_last) begin
                    w_timed_out_next = 1'b1;
                    w_state_next     = STOP;
                end
`else
                if (r_cnt == c_offer_last) begin
                    w_state_next = STOP;
                end
`endif
            end
            STOP: begin
                stop_offer   = 1'b1;
                w_state_next = SCAN;
            end
            SCAN: begin
                if (w_scan_done) begin
                    w_state_next = FINISH;
                end
            end
            FINISH: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State, phase counter and captured syndrome registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_syndrome  <= '0;
`ifdef GRID_DECODE_SEQ_EARLY_STOP_EN
            r_conv_run  <= '0;
            r_timed_out <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_syndrome  <= w_syndrome_next;
`ifdef GRID_DECODE_SEQ_EARLY_STOP_EN
            r_conv_run  <= w_conv_run_next;
            r_timed_out <= w_timed_out_next;
`endif
        end
    end

    defect_scanner #(
        .NUM_NODES         (NUM_NODES),
        .GRID_WIDTH        (GRID_WIDTH),
        .CORDINATE_WIDTH   (CORDINATE_WIDTH),
        .MATCH_VALUE_WIDTH (MATCH_VALUE_WIDTH)
    ) u_defect_scanner (
        .clk            (clk),
        .reset          (reset),
        .start          (w_scan_start),
        .scan_en        (w_scan_en),
        .syndrome       (r_syndrome),
        .match_value_in (match_value_in),
        .res_ready      (res_ready),
        .res_valid      (res_valid),
        .res_y          (res_y),
        .res_x          (res_x),
        .res_match      (res_match),
        .scan_done      (w_scan_done)
    );

endmodule : grid_decode_sequencer
`default_nettype wire
